// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity codes and baud helper for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// rtl/uart_tx_fifo_byte_fifo.sv - show-ahead synchronous byte FIFO feeding the serializer
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_q - rd_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_q == rd_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_top.sv
// rtl/uart_tx_fifo_top.sv - FIFO-buffered UART transmitter, LSB-first frames with optional parity
module uart_tx_fifo_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic                           txd,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam int             CPB        = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int             BW         = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0]  BAUD_LAST  = BW'(CPB - 1);
    localparam logic [2:0]     STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit             HAS_PARITY = (PARITY != PARITY_NONE);

    tx_state_t       state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            txd_q, txd_d;

    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_dout;
    logic            bit_end;
    logic            load;

    function automatic logic parity_bit(input logic [7:0] b);
        return (PARITY == PARITY_EVEN) ? ^b : ~^b;
    endfunction

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign txd      = txd_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign bit_end  = (baud_q == BAUD_LAST);

    // txd_d is the line level for the state being entered, so txd stays a pure flop output.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        load     = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                load  = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (HAS_PARITY) begin
                            state_d = uart_pkg::PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = 3'd0;
                        if (fifo_empty) begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Shared by IDLE and end-of-STOP so back-to-back frames have no idle gap.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            par_d    = parity_bit(fifo_dout);
            state_d  = START;
            baud_d   = '0;
            bit_d    = 3'd0;
            txd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// tb/tb_uart_tx_fifo_top.sv - directed self-checking bench, four parameter variants of the transmitter
module tb_uart_tx_fifo_top;

    localparam int NDUT = 4;
    localparam int CPB  = 16;
    localparam int PT [NDUT] = '{0, 2, 1, 2};
    localparam int ST [NDUT] = '{1, 1, 1, 2};

    logic       clk;
    logic       reset;
    logic [7:0] tx_data    [NDUT];
    logic       tx_valid   [NDUT];
    logic       tx_ready   [NDUT];
    logic       txd        [NDUT];
    logic       busy       [NDUT];
    logic [2:0] fifo_count [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int frame_busy;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_fifo_top #(
            .CLK_FREQ_HZ (1600),
            .BAUD_RATE   (100),
            .PARITY      (PT[g]),
            .STOP_BITS   (ST[g]),
            .FIFO_DEPTH  (4)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .tx_data    (tx_data[g]),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready[g]),
            .txd        (txd[g]),
            .busy       (busy[g]),
            .fifo_count (fifo_count[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_fall(input string tag, input int idx);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (txd[idx] === 1'b0) break;
        end
        check({tag, "_fall"}, 32'(txd[idx]), 32'd0);
    endtask

    // Entered on the first negedge of a start bit; returns on the first negedge after the frame.
    task automatic check_frame(input string tag, input int idx, input int npar, input int nstop,
                               input logic [7:0] exp_b, input logic exp_p);
        int         total;
        int         glitch;
        int         bhi;
        int         sbad;
        logic       v;
        logic       bv [12];
        logic [7:0] got_b;
        total  = (9 + npar + nstop) * CPB;
        glitch = 0;
        bhi    = 0;
        sbad   = 0;
        for (int c = 0; c < total; c++) begin
            v = txd[idx];
            if (c % CPB == 0) bv[c / CPB] = v;
            else if (v !== bv[c / CPB]) glitch++;
            if (busy[idx] === 1'b1) bhi++;
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) got_b[i] = bv[1 + i];
        for (int k = 0; k < nstop; k++) if (bv[9 + npar + k] !== 1'b1) sbad++;
        check({tag, "_start"}, 32'(bv[0]), 32'd0);
        check({tag, "_data"}, 32'(got_b), 32'(exp_b));
        if (npar != 0) check({tag, "_parity"}, 32'(bv[9]), 32'(exp_p));
        check({tag, "_stop"}, 32'(sbad), 32'd0);
        check({tag, "_hold"}, 32'(glitch), 32'd0);
        frame_busy += bhi;
    endtask

    task automatic push_bytes(input int idx, input logic [7:0] b [$]);
        logic r;
        foreach (b[i]) begin
            tx_data[idx]  = b[i];
            tx_valid[idx] = 1'b1;
            for (int n = 0; n < 400; n++) begin
                @(negedge clk);
                r = tx_ready[idx];
                @(posedge clk);
                #1;
                if (r) break;
            end
        end
        tx_valid[idx] = 1'b0;
    endtask

    task automatic count_low(input string tag, input int idx, input int cycles);
        int lows = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (txd[idx] !== 1'b1) lows++;
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            tx_data[i]  = 8'h00;
            tx_valid[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        @(negedge clk);
        check("rst_txd", 32'(txd[0]), 32'd1);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_ready", 32'(tx_ready[0]), 32'd1);
        check("rst_count", 32'(fifo_count[0]), 32'd0);

        // Single byte: latency, bit pattern, busy length.
        @(posedge clk);
        #1 tx_data[0] = 8'h55; tx_valid[0] = 1'b1;
        @(posedge clk);
        #1 tx_valid[0] = 1'b0;
        @(negedge clk);
        check("single_txd_n", 32'(txd[0]), 32'd1);
        check("single_count_n", 32'(fifo_count[0]), 32'd1);
        @(negedge clk);
        check("single_txd_n1", 32'(txd[0]), 32'd0);
        frame_busy = 0;
        check_frame("single", 0, 0, 1, 8'h55, 1'b0);
        check("single_busy_cycles", 32'(frame_busy), 32'd160);
        check("single_busy_end", 32'(busy[0]), 32'd0);
        check("single_count_end", 32'(fifo_count[0]), 32'd0);

        // Back-to-back frames.
        @(posedge clk);
        #1;
        frame_busy = 0;
        fork
            push_bytes(0, '{8'hA3, 8'h0F, 8'hFF});
            begin
                wait_fall("b2b", 0);
                check_frame("b2b0", 0, 0, 1, 8'hA3, 1'b0);
                check_frame("b2b1", 0, 0, 1, 8'h0F, 1'b0);
                check_frame("b2b2", 0, 0, 1, 8'hFF, 1'b0);
            end
        join
        check("b2b_busy_cycles", 32'(frame_busy), 32'd480);
        check("b2b_busy_end", 32'(busy[0]), 32'd0);

        // FIFO full: sixth byte and a data change while not ready are dropped.
        @(posedge clk);
        #1;
        fork
            begin
                push_bytes(0, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
                tx_data[0]  = 8'h66;
                tx_valid[0] = 1'b1;
                repeat (10) @(negedge clk);
                check("full_ready", 32'(tx_ready[0]), 32'd0);
                check("full_count", 32'(fifo_count[0]), 32'd4);
                tx_data[0] = 8'h77;
                repeat (10) @(negedge clk);
                check("full_ready2", 32'(tx_ready[0]), 32'd0);
                tx_valid[0] = 1'b0;
            end
            begin
                wait_fall("full", 0);
                check_frame("full0", 0, 0, 1, 8'h11, 1'b0);
                check_frame("full1", 0, 0, 1, 8'h22, 1'b0);
                check_frame("full2", 0, 0, 1, 8'h33, 1'b0);
                check_frame("full3", 0, 0, 1, 8'h44, 1'b0);
                check_frame("full4", 0, 0, 1, 8'h55, 1'b0);
            end
        join
        check("full_count_end", 32'(fifo_count[0]), 32'd0);
        count_low("full_no_extra", 0, 200);

        // Parity variants: even, odd, even with two stop bits.
        for (int d = 1; d < NDUT; d++) begin
            @(posedge clk);
            #1;
            frame_busy = 0;
            fork
                push_bytes(d, '{8'h07});
                begin
                    wait_fall($sformatf("par%0d", d), d);
                    check_frame($sformatf("par%0d", d), d, 1, ST[d], 8'h07, (PT[d] == 2) ? 1'b1 : 1'b0);
                end
            join
            check($sformatf("par%0d_cycles", d), 32'(frame_busy), (ST[d] == 2) ? 32'd192 : 32'd176);
            check($sformatf("par%0d_busy_end", d), 32'(busy[d]), 32'd0);
        end

        // Reset in data bit 3 with two bytes queued.
        @(posedge clk);
        #1;
        fork
            push_bytes(0, '{8'h00, 8'hAA, 8'hBB});
            begin
                wait_fall("rstm", 0);
                repeat (4 * CPB + 8) @(negedge clk);
                check("rstm_txd_pre", 32'(txd[0]), 32'd0);
                check("rstm_count_pre", 32'(fifo_count[0]), 32'd2);
                @(posedge clk);
                #2 reset = 1'b1;
                #1;
                check("rstm_txd", 32'(txd[0]), 32'd1);
                check("rstm_count", 32'(fifo_count[0]), 32'd0);
                check("rstm_busy", 32'(busy[0]), 32'd0);
                check("rstm_ready", 32'(tx_ready[0]), 32'd1);
            end
        join
        @(posedge clk);
        #2 reset = 1'b0;
        count_low("rstm_no_frames", 0, 400);
        check("rstm_busy_after", 32'(busy[0]), 32'd0);

        // Push and pop on the same edge at the end of a stop bit.
        @(posedge clk);
        #1;
        fork
            push_bytes(0, '{8'hC1, 8'hC2});
            begin
                wait_fall("pp", 0);
                repeat (159) @(negedge clk);
                check("pp_count_before", 32'(fifo_count[0]), 32'd1);
                tx_data[0]  = 8'hC3;
                tx_valid[0] = 1'b1;
                @(negedge clk);
                tx_valid[0] = 1'b0;
                check("pp_count_after", 32'(fifo_count[0]), 32'd1);
                check_frame("pp0", 0, 0, 1, 8'hC2, 1'b0);
                check_frame("pp1", 0, 0, 1, 8'hC3, 1'b0);
            end
        join
        check("pp_busy_end", 32'(busy[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_top.md
Name: uart_tx_fifo_top

Overview:
- Fabric-side UART transmitter: the sending end of the serial link whose receive end is the board's USB-UART chip.
- User logic pushes bytes through a valid/ready port into a small FIFO.
- Block serializes bytes as 8N1-style frames (optional parity) on txd, LSB first.
- Lets hardware logic emit debug/status bytes on the board UART without the MicroBlaze.

Parameters:
CLK_FREQ_HZ, 100_000_000, input clock frequency.
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division, truncating; 868 at defaults).
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits (1 or 2).
FIFO_DEPTH, 4, byte entries; power of two, >= 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid this cycle
tx_ready  output  1  FIFO can accept; equals not-full
txd  output  1  serial line, idle high, registered
busy  output  1  high while a frame is on the line or FIFO is non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): txd=1, busy=0, tx_ready=1, fifo_count=0, FSM=IDLE, counters=0, FIFO emptied.
- Push: a byte is written when tx_valid && tx_ready at the rising edge. When full, tx_ready=0 and tx_valid is ignored; no overwrite, no error flag.
- Push and pop in the same cycle: both take effect; fifo_count is unchanged.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts at the start of each bit. Each line bit is held for exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If the FIFO is non-empty at an edge, pop the head into the shift register and enter START. txd goes 0 on that same edge.
  - START: txd=0 for one bit time, then enter DATA.
  - DATA: txd = shift[0]; shift right after each bit. After 8 bits, enter PARITY if PARITY != 0, else STOP.
  - PARITY: txd = even ? ^byte : ~^byte, computed from the popped byte. Lasts one bit time, then STOP.
  - STOP: txd=1 for STOP_BITS bit times.
    - At the end of STOP, if the FIFO is non-empty, pop and go straight to START with no idle gap.
    - Otherwise go to IDLE.
- Frame length: (1 + 8 + (PARITY?1:0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: a byte pushed into an empty, idle block at edge N is popped at edge N+1; txd falls at edge N+1.
- busy = (state != IDLE) || (fifo_count != 0). It is registered-consistent with state and count.
- Reset mid-frame: txd returns to 1 immediately (async). The partial frame and all FIFO contents are discarded.
- tx_data and tx_valid changing while tx_ready=0 has no effect.

Decomposition:
- Package uart_pkg:
  - enum type tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparams PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2;
  - function clks_per_bit(freq, baud).
- Sub-module byte_fifo: parameterised synchronous FIFO with DEPTH and WIDTH=8.
  - Ports: push, pop, din, dout (show-ahead head), full, empty, count.
  - Same clk and async reset.
- Top holds the baud counter, bit counter, shift register and FSM.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=1600, BAUD_RATE=100, so CLKS_PER_BIT=16.
- Single byte: push 0x55 when idle. Required response:
  - txd falls one edge later;
  - line sequence 0,1,0,1,0,1,0,1,0,1, each held 16 cycles;
  - busy drops after 160 cycles;
  - fifo_count returns to 0.
- Back-to-back frames: push 0xA3, 0x0F, 0xFF on consecutive cycles.
  - Three frames with no idle high between the stop bit and the next start bit.
  - Decoded bytes are 0xA3, 0x0F, 0xFF; 480 cycles in total.
- FIFO full: hold tx_valid with 6 distinct bytes while the first frame is in progress.
  - 1 byte is popped, 4 are queued, and tx_ready=0 while full.
  - Extra bytes are dropped; exactly 5 frames are sent, in order.
- Parity: PARITY=2, push 0x07 -> parity bit 1. PARITY=1, push 0x07 -> parity bit 0.
  - Frame is 11 bits = 176 cycles; STOP_BITS=2 gives 192 cycles.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued.
  - txd=1 immediately; fifo_count=0, busy=0, tx_ready=1.
  - No further frames after release.
- Simultaneous push/pop: FIFO holds 1 byte at the end of STOP while a push occurs on the same edge.
  - fifo_count stays 1.
  - Next frame carries the older byte.
